// File: rtl/elliptic_curve_structs.sv
// rtl/elliptic_curve_structs.sv - shared point type, case enumeration and curve constants
package elliptic_curve_structs;

  localparam int EC_WIDTH = 256;
  localparam logic [255:0] SECP256K1_P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  // Coordinates are EC_WIDTH wide; narrower units use the low WIDTH bits and keep the rest zero.
  typedef struct packed {
    logic [EC_WIDTH-1:0] x;
    logic [EC_WIDTH-1:0] y;
    logic                inf;
  } ec_point_t;

  typedef enum logic [1:0] {
    KIND_BYPASS = 2'd0,
    KIND_ADD    = 2'd1,
    KIND_DOUBLE = 2'd2,
    KIND_INF    = 2'd3
  } ec_kind_e;

endpackage

// File: rtl/point_add_unit_if.sv
// rtl/point_add_unit_if.sv - request/response handshake bundle of the point add unit
interface point_add_unit_if #(
  parameter int TAG_W = 8
);
  import elliptic_curve_structs::*;

  logic             in_valid;
  logic             in_ready;
  ec_point_t        in_P;
  ec_point_t        in_Q;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  ec_point_t        out_R;
  logic [TAG_W-1:0] out_tag;
  ec_kind_e         out_kind;

  modport master (
    output in_valid, in_P, in_Q, in_tag, out_ready,
    input  in_ready, out_valid, out_R, out_tag, out_kind
  );

  modport slave (
    input  in_valid, in_P, in_Q, in_tag, out_ready,
    output in_ready, out_valid, out_R, out_tag, out_kind
  );

endinterface

// File: rtl/ec_field_core.sv
// rtl/ec_field_core.sv - sequential slope/point engine shared by point_add and point_double
module ec_field_core
  import elliptic_curve_structs::*;
#(
  parameter int               WIDTH   = 256,
  parameter logic [WIDTH-1:0] MODULUS = SECP256K1_P[WIDTH-1:0],
  parameter bit               DOUBLE  = 1'b0
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y1,
  input  logic [WIDTH-1:0] x2,
  input  logic [WIDTH-1:0] y2,
  output logic             Done,
  output logic [WIDTH-1:0] x3,
  output logic [WIDTH-1:0] y3
);

  localparam int               IW  = $clog2(WIDTH);
  localparam logic [IW-1:0]    TOP = IW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] EXP = MODULUS - WIDTH'(2);

  typedef enum logic [2:0] {PH_SQ, PH_INV_SQ, PH_INV_MUL, PH_LAM, PH_L2, PH_T, PH_DONE} phase_e;

  phase_e           phase;
  logic [WIDTH-1:0] acc, num_r, inv, lam;
  logic [WIDTH-1:0] num, den, op_a, op_b, mul_next;
  logic [IW-1:0]    bit_idx, exp_idx;

  function automatic logic [WIDTH-1:0] add_mod(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, MODULUS}) s = s - {1'b0, MODULUS};
    return s[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[WIDTH]) d = d + {1'b0, MODULUS};
    return d[WIDTH-1:0];
  endfunction

  // One MSB-first double-and-add multiplier; operands stay stable because they only change on completion.
  always_comb begin
    num  = DOUBLE ? num_r : sub_mod(y2, y1);
    den  = DOUBLE ? add_mod(y1, y1) : sub_mod(x2, x1);
    op_a = lam;
    op_b = lam;
    case (phase)
      PH_SQ:      begin op_a = x1;  op_b = x1;  end
      PH_INV_SQ:  begin op_a = inv; op_b = inv; end
      PH_INV_MUL: begin op_a = inv; op_b = den; end
      PH_LAM:     begin op_a = num; op_b = inv; end
      PH_T:       begin op_a = lam; op_b = sub_mod(x1, x3); end
      default:    ;
    endcase
    mul_next = add_mod(add_mod(acc, acc), op_b[bit_idx] ? op_a : '0);
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      if (DOUBLE) phase <= PH_SQ;
      else        phase <= PH_INV_SQ;
      acc     <= '0;
      bit_idx <= TOP;
      exp_idx <= TOP;
      inv     <= WIDTH'(1);
      num_r   <= '0;
      lam     <= '0;
      x3      <= '0;
      y3      <= '0;
      Done    <= 1'b0;
    end else if (phase != PH_DONE) begin
      acc     <= mul_next;
      bit_idx <= bit_idx - IW'(1);
      if (bit_idx == '0) begin
        acc     <= '0;
        bit_idx <= TOP;
        case (phase)
          PH_SQ: begin
            num_r <= add_mod(add_mod(mul_next, mul_next), mul_next);
            phase <= PH_INV_SQ;
          end
          // Fermat inverse: den^(MODULUS-2) by left-to-right square-and-multiply.
          PH_INV_SQ: begin
            inv <= mul_next;
            if (EXP[exp_idx])        phase   <= PH_INV_MUL;
            else if (exp_idx == '0)  phase   <= PH_LAM;
            else                     exp_idx <= exp_idx - IW'(1);
          end
          PH_INV_MUL: begin
            inv <= mul_next;
            if (exp_idx == '0) phase <= PH_LAM;
            else begin
              exp_idx <= exp_idx - IW'(1);
              phase   <= PH_INV_SQ;
            end
          end
          PH_LAM: begin
            lam   <= mul_next;
            phase <= PH_L2;
          end
          PH_L2: begin
            x3    <= sub_mod(sub_mod(mul_next, x1), x2);
            phase <= PH_T;
          end
          PH_T: begin
            y3    <= sub_mod(mul_next, y1);
            Done  <= 1'b1;
            phase <= PH_DONE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/point_add.sv
// rtl/point_add.sv - affine addition of two distinct, non-inverse points (y^2 = x^3 + 7)
module point_add
  import elliptic_curve_structs::*;
#(
  parameter int               WIDTH   = 256,
  parameter logic [WIDTH-1:0] MODULUS = SECP256K1_P[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y1,
  input  logic [WIDTH-1:0] x2,
  input  logic [WIDTH-1:0] y2,
  output logic             Done,
  output logic [WIDTH-1:0] x3,
  output logic [WIDTH-1:0] y3
);

  ec_field_core #(.WIDTH(WIDTH), .MODULUS(MODULUS), .DOUBLE(1'b0)) u_core (
    .clk(clk), .Reset(Reset), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
    .Done(Done), .x3(x3), .y3(y3)
  );

endmodule

// File: rtl/point_case_classify.sv
// rtl/point_case_classify.sv - picks bypass/add/double/inverse case and the bypass result
module point_case_classify
  import elliptic_curve_structs::*;
#(
  parameter int WIDTH = 256
) (
  input  ec_point_t p,
  input  ec_point_t q,
  output ec_kind_e  kind,
  output ec_point_t bypass
);

  logic      x_eq, y_eq, y_zero;
  ec_point_t sel;

  always_comb begin
    x_eq   = (p.x[WIDTH-1:0] == q.x[WIDTH-1:0]);
    y_eq   = (p.y[WIDTH-1:0] == q.y[WIDTH-1:0]);
    y_zero = (p.y[WIDTH-1:0] == '0);
    sel    = p.inf ? q : p;
    bypass = '0;
    kind   = KIND_ADD;
    // Infinity results always carry zero coordinates, whatever the operand held.
    if (p.inf || q.inf) begin
      kind       = KIND_BYPASS;
      bypass.inf = sel.inf;
      if (!sel.inf) begin
        bypass.x[WIDTH-1:0] = sel.x[WIDTH-1:0];
        bypass.y[WIDTH-1:0] = sel.y[WIDTH-1:0];
      end
    end else if (x_eq && (!y_eq || y_zero)) begin
      kind       = KIND_INF;
      bypass.inf = 1'b1;
    end else if (x_eq) begin
      kind = KIND_DOUBLE;
    end
  end

endmodule

// File: rtl/point_double.sv
// rtl/point_double.sv - affine doubling of a point with y != 0 (y^2 = x^3 + 7)
module point_double
  import elliptic_curve_structs::*;
#(
  parameter int               WIDTH   = 256,
  parameter logic [WIDTH-1:0] MODULUS = SECP256K1_P[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             Done,
  output logic [WIDTH-1:0] x3,
  output logic [WIDTH-1:0] y3
);

  ec_field_core #(.WIDTH(WIDTH), .MODULUS(MODULUS), .DOUBLE(1'b1)) u_core (
    .clk(clk), .Reset(Reset), .x1(x), .y1(y), .x2(x), .y2(y),
    .Done(Done), .x3(x3), .y3(y3)
  );

endmodule

// File: rtl/point_add_unit.sv
// rtl/point_add_unit.sv - request/response wrapper choosing bypass, add or double per request
module point_add_unit
  import elliptic_curve_structs::*;
#(
  parameter int               WIDTH   = 256,
  parameter logic [WIDTH-1:0] MODULUS = SECP256K1_P[WIDTH-1:0],
  parameter int               TAG_W   = 8
) (
  input  logic            clk,
  input  logic            Reset_n,
  point_add_unit_if.slave bus,
  output logic            busy,
  output logic [15:0]     op_cycles
);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DBL, S_HOLD} state_e;

  state_e           state;
  ec_point_t        r_r, byp;
  ec_kind_e         kind_r, cls_kind;
  logic [TAG_W-1:0] tag_r;
  logic [WIDTH-1:0] px, py, qx, qy, add_x, add_y, dbl_x, dbl_y;
  logic             add_reset, dbl_reset, add_done, dbl_done;

  function automatic ec_point_t mk_point(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    ec_point_t pt;
    pt = '0;
    pt.x[WIDTH-1:0] = x;
    pt.y[WIDTH-1:0] = y;
    return pt;
  endfunction

  point_case_classify #(.WIDTH(WIDTH)) u_cls (
    .p(bus.in_P), .q(bus.in_Q), .kind(cls_kind), .bypass(byp)
  );

  // Each sub-unit runs only while its own state is active; reset of the FSM therefore resets both.
  assign add_reset = (state != S_ADD);
  assign dbl_reset = (state != S_DBL);

  point_add #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_add (
    .clk(clk), .Reset(add_reset), .x1(px), .y1(py), .x2(qx), .y2(qy),
    .Done(add_done), .x3(add_x), .y3(add_y)
  );

  point_double #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_dbl (
    .clk(clk), .Reset(dbl_reset), .x(px), .y(py),
    .Done(dbl_done), .x3(dbl_x), .y3(dbl_y)
  );

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= S_IDLE;
      px        <= '0;
      py        <= '0;
      qx        <= '0;
      qy        <= '0;
      r_r       <= '0;
      tag_r     <= '0;
      kind_r    <= KIND_BYPASS;
      op_cycles <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (bus.in_valid) begin
          px        <= bus.in_P.x[WIDTH-1:0];
          py        <= bus.in_P.y[WIDTH-1:0];
          qx        <= bus.in_Q.x[WIDTH-1:0];
          qy        <= bus.in_Q.y[WIDTH-1:0];
          tag_r     <= bus.in_tag;
          kind_r    <= cls_kind;
          r_r       <= byp;
          op_cycles <= 16'd1;
          case (cls_kind)
            KIND_ADD:    state <= S_ADD;
            KIND_DOUBLE: state <= S_DBL;
            default:     state <= S_HOLD;
          endcase
        end
        S_ADD, S_DBL: begin
          if (op_cycles != 16'hFFFF) op_cycles <= op_cycles + 16'd1;
          if ((state == S_ADD) ? add_done : dbl_done) begin
            r_r   <= (state == S_ADD) ? mk_point(add_x, add_y) : mk_point(dbl_x, dbl_y);
            state <= S_HOLD;
          end
        end
        S_HOLD: if (bus.out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = Reset_n && (state == S_IDLE);
  assign bus.out_valid = (state == S_HOLD);
  assign bus.out_R     = r_r;
  assign bus.out_tag   = tag_r;
  assign bus.out_kind  = kind_r;
  assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_point_add_unit.sv
// tb/tb_point_add_unit.sv - directed bench for point_add_unit on y^2 = x^3 + 7 over GF(17)
module tb_point_add_unit;
  import elliptic_curve_structs::*;

  logic        clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        busy;
  logic [15:0] op_cycles;
  int          errors = 0;
  int          checks = 0;
  int          add_live = 0;

  point_add_unit_if #(.TAG_W(8)) bus ();

  point_add_unit #(.WIDTH(8), .MODULUS(8'd17), .TAG_W(8)) dut (
    .clk(clk), .Reset_n(Reset_n), .bus(bus), .busy(busy), .op_cycles(op_cycles)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!dut.add_reset) add_live++;

  function automatic ec_point_t mk(input int x, input int y, input bit inf);
    ec_point_t pt;
    pt     = '0;
    pt.x   = EC_WIDTH'(x);
    pt.y   = EC_WIDTH'(y);
    pt.inf = inf;
    return pt;
  endfunction

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_req(input string name, input ec_point_t p, input ec_point_t q,
                         input logic [7:0] tag, input logic [1:0] kind,
                         input ec_point_t r, input int stall);
    int n;
    int cyc;
    @(negedge clk);
    bus.in_P     = p;
    bus.in_Q     = q;
    bus.in_tag   = tag;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
    check({name, ".accept"}, bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    cyc = 1;
    while (!bus.out_valid && cyc < 2000) begin @(negedge clk); cyc++; end
    check({name, ".valid"}, bus.out_valid, 1);
    check({name, ".kind"}, bus.out_kind, kind);
    check({name, ".x"}, bus.out_R.x, r.x);
    check({name, ".y"}, bus.out_R.y, r.y);
    check({name, ".inf"}, bus.out_R.inf, r.inf);
    check({name, ".tag"}, bus.out_tag, tag);
    check({name, ".cycles"}, op_cycles, cyc);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({name, ".stall_x"}, bus.out_R.x, r.x);
      check({name, ".stall_tag"}, bus.out_tag, tag);
      check({name, ".stall_inready"}, bus.in_ready, 0);
      check({name, ".stall_valid"}, bus.out_valid, 1);
    end
    bus.out_ready = 1'b1;
    #1 check({name, ".retire_inready"}, bus.in_ready, 0);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({name, ".retired"}, bus.out_valid, 0);
    check({name, ".idle_ready"}, bus.in_ready, 1);
  endtask

  ec_point_t  b2b_p [3];
  ec_point_t  b2b_q [3];
  logic [7:0] b2b_tag [3];
  int         live0;
  int         extra;

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_P      = '0;
    bus.in_Q      = '0;
    bus.in_tag    = '0;

    repeat (2) @(negedge clk);
    check("rst.in_ready", bus.in_ready, 0);
    check("rst.out_valid", bus.out_valid, 0);
    check("rst.busy", busy, 0);
    check("rst.op_cycles", op_cycles, 0);
    check("rst.kind", bus.out_kind, 0);
    check("rst.tag", bus.out_tag, 0);
    check("rst.R", bus.out_R, 0);
    Reset_n = 1'b1;
    #1 check("rel.in_ready", bus.in_ready, 1);

    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("idle.out_valid", bus.out_valid, 0);
    check("idle.busy", busy, 0);
    bus.out_ready = 1'b0;

    run_req("add",  mk(1, 5, 0),  mk(2, 10, 0), 8'h11, 2'd1, mk(5, 9, 0), 0);
    live0 = add_live;
    run_req("dbl",  mk(1, 5, 0),  mk(1, 5, 0),  8'h22, 2'd2, mk(2, 10, 0), 0);
    check("dbl.add_held", add_live - live0, 0);
    run_req("inv",  mk(1, 5, 0),  mk(1, 12, 0), 8'h33, 2'd3, mk(0, 0, 1), 0);
    check("inv.op_cycles", op_cycles, 1);
    run_req("pinf", mk(7, 7, 1),  mk(2, 10, 0), 8'h44, 2'd0, mk(2, 10, 0), 5);
    run_req("qinf", mk(2, 10, 0), mk(3, 4, 1),  8'h45, 2'd0, mk(2, 10, 0), 0);
    run_req("binf", mk(7, 7, 1),  mk(3, 4, 1),  8'h46, 2'd0, mk(0, 0, 1), 0);
    run_req("y0",   mk(3, 0, 0),  mk(3, 0, 0),  8'h47, 2'd3, mk(0, 0, 1), 0);
    run_req("add2", mk(2, 10, 0), mk(5, 9, 0),  8'h48, 2'd1, mk(12, 16, 0), 0);

    // Abandon a doubling part-way through with an asynchronous reset pulse.
    @(negedge clk);
    bus.in_P = mk(1, 5, 0); bus.in_Q = mk(1, 5, 0); bus.in_tag = 8'h55; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("mid.busy", busy, 1);
    #2 Reset_n = 1'b0;
    #1;
    check("mid.out_valid", bus.out_valid, 0);
    check("mid.in_ready", bus.in_ready, 0);
    check("mid.busy_rst", busy, 0);
    check("mid.op_cycles", op_cycles, 0);
    check("mid.R", bus.out_R, 0);
    check("mid.tag", bus.out_tag, 0);
    repeat (2) @(negedge clk);
    Reset_n = 1'b1;
    #1 check("mid.in_ready_rel", bus.in_ready, 1);
    extra = 0;
    repeat (200) begin @(negedge clk); if (bus.out_valid || busy) extra++; end
    check("mid.no_result", extra, 0);
    run_req("post", mk(1, 5, 0), mk(2, 10, 0), 8'h66, 2'd1, mk(5, 9, 0), 0);

    b2b_p[0] = mk(1, 5, 0);  b2b_q[0] = mk(1, 12, 0); b2b_tag[0] = 8'hA1;
    b2b_p[1] = mk(1, 5, 0);  b2b_q[1] = mk(2, 10, 0); b2b_tag[1] = 8'hA2;
    b2b_p[2] = mk(0, 0, 1);  b2b_q[2] = mk(5, 9, 0);  b2b_tag[2] = 8'hA3;
    bus.out_ready = 1'b1;
    fork
      begin : drv
        int n;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          bus.in_P = b2b_p[i]; bus.in_Q = b2b_q[i]; bus.in_tag = b2b_tag[i]; bus.in_valid = 1'b1;
          n = 0;
          while (!bus.in_ready && n < 300) begin @(negedge clk); n++; end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
      end
      begin : col
        int got;
        got = 0;
        for (int c = 0; c < 800 && got < 3; c++) begin
          @(negedge clk);
          if (bus.out_valid) begin
            check("b2b.tag", bus.out_tag, b2b_tag[got]);
            check("b2b.retire_inready", bus.in_ready, 0);
            got++;
          end
        end
        check("b2b.count", got, 3);
      end
    join
    extra = 0;
    repeat (10) begin @(negedge clk); if (bus.out_valid) extra++; end
    check("b2b.no_extra", extra, 0);
    bus.out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/point_add_unit.md
POINT_ADD_UNIT -- requirements
Module: point_add_unit

Interface
REQ-001 Parameter WIDTH, default 256: coordinate width in bits.
REQ-002 Parameter MODULUS, default secp256k1 field prime: field modulus forwarded to sub-modules.
REQ-003 Parameter TAG_W, default 8: width of opaque request tag.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 Reset_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  request present; in_ready  out  1  unit accepts request.
REQ-007 in_P, in_Q  in  ec_point_t (x, y: WIDTH each; inf: 1)  operands; in_tag  in  TAG_W.
REQ-008 out_valid  out  1  result present; out_ready  in  1  consumer accepts result.
REQ-009 out_R  out  ec_point_t  result; out_tag  out  TAG_W  echo of in_tag.
REQ-010 out_kind  out  2  case taken: 0 bypass, 1 add, 2 double, 3 inverse-to-infinity.
REQ-011 busy  out  1  high in any state other than IDLE.
REQ-012 op_cycles  out  16  cycles from accept to out_valid of last result, saturating at 0xFFFF.

Function
REQ-013 States: IDLE, ADD, DBL, HOLD; transfer on in_valid&in_ready (accept) and out_valid&out_ready (retire).
REQ-014 in_ready SHALL be high only in IDLE; at accept, P, Q, tag registered.
REQ-015 Classification at accept, priority order: P.inf -> R=Q, kind 0; Q.inf -> R=P, kind 0; P.x==Q.x & P.y!=Q.y -> R=inf, kind 3; P==Q & P.y==0 -> R=inf, kind 3; P==Q -> DBL, kind 2; else ADD, kind 1.
REQ-016 Kinds 0 and 3 SHALL go IDLE->HOLD in one cycle: out_valid the cycle after accept.
REQ-017 ADD/DBL: only the selected sub-unit released from reset; on its Done, R captured, inf=0, go HOLD.
REQ-018 Non-selected sub-unit SHALL be held in reset throughout; its outputs ignored.
REQ-019 HOLD: out_valid high, out_R/out_tag/out_kind stable until retire; retire -> IDLE.
REQ-020 No new request accepted in the retire cycle (in_ready rises the cycle after).
REQ-021 out_ready while out_valid low SHALL have no effect; in_valid low in IDLE keeps IDLE.
REQ-022 Result point with inf=1 SHALL have x=y=0.
REQ-023 op_cycles counter cleared at accept, incremented each cycle until out_valid, latched in HOLD.
REQ-024 Equality compares all WIDTH bits; operands assumed reduced mod MODULUS, no range check.

Reset
REQ-025 Reset_n low SHALL asynchronously force IDLE, in_ready=0 during reset, out_valid=0, busy=0, out_R=0 with inf=0, out_tag=0, out_kind=0, op_cycles=0.
REQ-026 Both sub-units SHALL be held in reset while Reset_n low; reset mid-ADD/DBL abandons the operation, no result emitted.
REQ-027 First accept possible on the first clock edge after Reset_n deasserts (in_ready=1 in IDLE).

Structure
REQ-028 ec_point_t (x, y, inf) and the out_kind enumeration SHALL live in elliptic_curve_structs, parameterised by WIDTH through a package localparam.
REQ-029 Existing point_add and point_double SHALL be reused as-is, parameterised by WIDTH/MODULUS, active-high Reset driven internally.
REQ-030 Combinational case detection SHALL be a sub-module point_case_classify (inputs P, Q; outputs kind, bypass point).

Verification (WIDTH=8, MODULUS=17, curve y^2=x^3+7)
REQ-031 P=(1,5), Q=(2,10) -> kind 1, R=(5,9), inf=0, tag echoed.
REQ-032 P=Q=(1,5) -> kind 2, R=(2,10); point_add held in reset throughout.
REQ-033 P=(1,5), Q=(1,12) -> kind 3, R inf=1, x=y=0, out_valid cycle after accept, op_cycles=1.
REQ-034 P.inf=1, Q=(2,10) -> kind 0, R=(2,10); out_ready low 5 cycles -> out_R stable, in_ready low.
REQ-035 Reset_n pulsed low mid-DBL -> out_valid 0, IDLE, no result; next request P=(1,5), Q=(2,10) gives R=(5,9).
REQ-036 Back-to-back requests with out_ready held high -> exactly one result per request, tags in order, in_ready low in each retire cycle.
